dbi_init_seq: RTL and testbench
===============================

# dbi_init_seq

Power-on initialisation sequencer for the DBI display path. It sits in front of the DBI TX FSM's configuration channels (type / command / data) and mode input. It issues a fixed panel bring-up script: hardware reset, sleep-out, sleep-out wait, MADCTL, COLMOD, CASET, RASET, DISPON. It then switches the controller to stream mode so pixel traffic can flow.

## Interface
- `INTERNAL_CLK`, 125000000, clock frequency in Hz
- `DBI_IF_D_W`, 8, DBI byte width
- `DISP_W`, 240, panel columns; CASET end = DISP_W-1
- `DISP_H`, 320, panel rows; RASET end = DISP_H-1
- `MADCTL_VAL`, 8'h48, MADCTL parameter byte
- `COLMOD_VAL`, 8'h55, COLMOD parameter byte
- `SLP_WAIT_MS`, 6, wait after SLPOUT, in ms
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous reset, active-low
- `start_i`  in  1  one-cycle pulse; starts or restarts the script
- `dbi_ctrl_mode_o`  out  2  0 = IDLE, 1 = CONF, 2 = STREAM
- `dbi_mem_com_o`  out  DBI_IF_D_W  constant 8'h2C (RAMWR)
- `tx_type_rw_o`  out  1  constant 0 (write)
- `tx_type_hrst_o`  out  1  current transaction is a hardware reset
- `tx_type_dat_amt_o`  out  3  data bytes in current transaction (0..4)
- `tx_type_vld_o` / `tx_type_rdy_i`  out / in  1  type channel handshake
- `tx_com_o`  out  DBI_IF_D_W  command byte
- `tx_com_vld_o` / `tx_com_rdy_i`  out / in  1  command channel handshake
- `tx_data_o`  out  DBI_IF_D_W  current parameter byte
- `tx_data_vld_o` / `tx_data_rdy_i`  out / in  1  data channel handshake
- `busy_o`  out  1  script in progress
- `init_done_o`  out  1  script complete; remains high until next start or reset

## Operation
- States:
  - IDLE
  - ISSUE: a step is presented on the channels
  - SLP_WAIT
  - DONE
- Step ROM, 3-bit index `step_q` (hrst / cmd / amt / data bytes):
  - 0: 1 / 8'h00 / 0
  - 1: 0 / 8'h11 / 0
  - 2: 0 / 8'h36 / 1 / MADCTL_VAL
  - 3: 0 / 8'h3A / 1 / COLMOD_VAL
  - 4: 0 / 8'h2A / 4 / 00, 00, (DISP_W-1)[15:8], (DISP_W-1)[7:0]
  - 5: 0 / 8'h2B / 4 / 00, 00, (DISP_H-1)[15:8], (DISP_H-1)[7:0]
  - 6: 0 / 8'h29 / 0
- IDLE:
  - on start: `step_q`=0, byte index `byte_q`=0, → ISSUE.
- ISSUE:
  - `tx_type_vld_o`=1.
  - `tx_com_vld_o`=~hrst.
  - `tx_data_vld_o`=(amt≠0)&~hrst.
  - `tx_data_o`=ROM[step][byte_q].
  - Data beat: `tx_data_vld_o & tx_data_rdy_i`, `byte_q`+1; saturates at amt-1.
  - Step done: `tx_type_vld_o & tx_type_rdy_i` → `byte_q`=0.
  - After step 1 → SLP_WAIT. After step 6 → DONE. Otherwise `step_q`+1, stay in ISSUE.
- SLP_WAIT:
  - Counter loads SLP_WAIT_CYC-1, where SLP_WAIT_CYC = (INTERNAL_CLK/1000)*SLP_WAIT_MS.
  - Decrements each cycle; at 0 → ISSUE with `step_q`=2.
  - Counter width = $clog2(SLP_WAIT_CYC+1).
- DONE: mode=STREAM, `init_done_o`=1. `start_i` → IDLE actions (restart).
- The post-reset 120 ms stall is owned downstream: step 1 stays valid and is not accepted until the TX FSM returns to idle.
- Mode output:
  - CONF in ISSUE and SLP_WAIT.
  - STREAM in DONE.
  - IDLE in IDLE.
- Restart from DONE: mode returns to CONF immediately. An in-flight stream burst completes downstream before the step 0 type handshake can occur.
- `start_i` in ISSUE or SLP_WAIT is ignored.

## Timing
- Reset values:
  - state=IDLE, all `*_vld_o`=0, `dbi_ctrl_mode_o`=0, `busy_o`=0, `init_done_o`=0.
  - `tx_type_hrst_o`=0, `tx_type_dat_amt_o`=0, `tx_com_o`=0, `tx_data_o`=0.
- Constant outputs: `dbi_mem_com_o`=8'h2C, `tx_type_rw_o`=0.
- Step outputs are decoded from registered `step_q`/`byte_q`/state; they never depend on ready inputs.
- First valid appears 1 cycle after the `start_i` edge.
- Valid, command and amount are held stable until the type handshake.
- Data and type may handshake in the same cycle on the last byte: that cycle counts the beat and completes the step.
- Next step is valid the cycle after the handshake (no bubble), except after step 1, which inserts SLP_WAIT_CYC cycles.
- `init_done_o` rises the cycle after the step-6 handshake.
- Reset asserted mid-script: immediate return to reset values; no partial state retained.

## Configuration
- `DBI_INIT_AUTO_START_EN`
  - Defined: the first clock after reset release acts as an internal start; the script runs without `start_i`.
  - Undefined: the script runs only on `start_i`; the block sits in IDLE (mode 0) otherwise.

## Test plan
- `INTERNAL_CLK`=1000, `SLP_WAIT_MS`=6, all readies tied high, `start_i` pulse:
  - Required sequence: step 0 (hrst=1), step 1 (8'h11), exactly 6 wait cycles, then 8'h36/48, 8'h3A/55.
  - Then 8'h2A with bytes 00, 00, 00, EF and 8'h2B with bytes 00, 00, 01, 3F.
  - Then 8'h29, followed by `init_done_o`=1 and mode=2.
- Backpressure: `tx_data_rdy_i` high every 3rd cycle during CASET, type/com ready only with the last byte → 4 data beats, `tx_com_o`=8'h2A held stable throughout, no byte skipped or repeated.
- Step 0 held unaccepted for 50 cycles → `tx_type_vld_o` stays 1, `tx_type_hrst_o` stays 1, `busy_o`=1, `step_q` unchanged.
- `start_i` pulsed during SLP_WAIT → ignored; the wait count completes unchanged.
- `start_i` in DONE → mode goes 2→1; the script reruns from step 0 with identical bytes.
- `rst_n` low during RASET byte 2 → all valids 0 and mode 0 within the same cycle. With `DBI_INIT_AUTO_START_EN` defined, the script restarts at step 0 after release; without it, the block stays in IDLE.

Source files
------------

// File: rtl/dbi_init_seq_if.sv
// dbi_init_seq_if: DBI TX configuration channels (type / command / data) between the init sequencer and the TX FSM.
// master drives type/com/data payload and valids and takes readies; slave is the mirror view.
interface dbi_init_seq_if #(
  parameter int DBI_IF_D_W = 8
);
  logic                  tx_type_rw_o;
  logic                  tx_type_hrst_o;
  logic [2:0]            tx_type_dat_amt_o;
  logic                  tx_type_vld_o;
  logic                  tx_type_rdy_i;
  logic [DBI_IF_D_W-1:0] tx_com_o;
  logic                  tx_com_vld_o;
  logic                  tx_com_rdy_i;
  logic [DBI_IF_D_W-1:0] tx_data_o;
  logic                  tx_data_vld_o;
  logic                  tx_data_rdy_i;
  modport master (
    output tx_type_rw_o, tx_type_hrst_o, tx_type_dat_amt_o, tx_type_vld_o,
    output tx_com_o, tx_com_vld_o, tx_data_o, tx_data_vld_o,
    input  tx_type_rdy_i, tx_com_rdy_i, tx_data_rdy_i
  );
  modport slave (
    input  tx_type_rw_o, tx_type_hrst_o, tx_type_dat_amt_o, tx_type_vld_o,
    input  tx_com_o, tx_com_vld_o, tx_data_o, tx_data_vld_o,
    output tx_type_rdy_i, tx_com_rdy_i, tx_data_rdy_i
  );
endinterface

// File: rtl/dbi_init_seq.sv
// dbi_init_seq: power-on panel bring-up script (HW reset, SLPOUT, wait, MADCTL, COLMOD, CASET, RASET, DISPON), then stream mode.
// Ports: clk, rst_n (async, active-low), start_i (start/restart pulse), dbi_ctrl_mode_o (0 idle/1 conf/2 stream),
// dbi_mem_com_o (RAMWR constant), busy_o, init_done_o, tx (type/command/data channels, master side).
// Optional: define DBI_INIT_AUTO_START_EN to start the script on the first clock after reset release.
module dbi_init_seq #(
  parameter int         INTERNAL_CLK = 125000000,
  parameter int         DBI_IF_D_W   = 8,
  parameter int         DISP_W       = 240,
  parameter int         DISP_H       = 320,
  parameter logic [7:0] MADCTL_VAL   = 8'h48,
  parameter logic [7:0] COLMOD_VAL   = 8'h55,
  parameter int         SLP_WAIT_MS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [1:0]            dbi_ctrl_mode_o,
  output logic [DBI_IF_D_W-1:0] dbi_mem_com_o,
  output logic                  busy_o,
  output logic                  init_done_o,
  dbi_init_seq_if.master        tx
);
  localparam int SLP_WAIT_CYC = (INTERNAL_CLK / 1000) * SLP_WAIT_MS;
  localparam int CW = $clog2(SLP_WAIT_CYC + 1);
  localparam logic [15:0] COL_END = 16'(DISP_W - 1);
  localparam logic [15:0] ROW_END = 16'(DISP_H - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, SLP_WAIT, DONE} state_t;
  state_t        state_q;
  logic [2:0]    step_q;
  logic [1:0]    byte_q;
  logic [CW-1:0] cnt_q;
  logic          hrst, issue, start, type_hs, data_hs;
  logic [2:0]    amt;
  logic [7:0]    cmd, dat;
`ifdef DBI_INIT_AUTO_START_EN
  logic armed_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed_q <= 1'b1;
    else armed_q <= 1'b0;
  assign start = start_i | armed_q;
`else
  assign start = start_i;
`endif
  always_comb begin
    hrst = 1'b0;
    cmd  = 8'h00;
    amt  = 3'd0;
    dat  = 8'h00;
    case (step_q)
      3'd0: hrst = 1'b1;
      3'd1: cmd = 8'h11;
      3'd2: {cmd, amt, dat} = {8'h36, 3'd1, MADCTL_VAL};
      3'd3: {cmd, amt, dat} = {8'h3A, 3'd1, COLMOD_VAL};
      3'd4: {cmd, amt, dat} = {8'h2A, 3'd4, byte_q == 2'd2 ? COL_END[15:8] : byte_q == 2'd3 ? COL_END[7:0] : 8'h00};
      3'd5: {cmd, amt, dat} = {8'h2B, 3'd4, byte_q == 2'd2 ? ROW_END[15:8] : byte_q == 2'd3 ? ROW_END[7:0] : 8'h00};
      3'd6: cmd = 8'h29;
      default: ;
    endcase
  end
  // payload is gated by state so every output is zero outside ISSUE and never looks at a ready
  assign issue                = state_q == ISSUE;
  assign tx.tx_type_rw_o      = 1'b0;
  assign tx.tx_type_vld_o     = issue;
  assign tx.tx_type_hrst_o    = issue & hrst;
  assign tx.tx_type_dat_amt_o = issue ? amt : 3'd0;
  assign tx.tx_com_vld_o      = issue & ~hrst;
  assign tx.tx_com_o          = issue ? DBI_IF_D_W'(cmd) : '0;
  assign tx.tx_data_vld_o     = issue & ~hrst & (amt != 3'd0);
  assign tx.tx_data_o         = issue ? DBI_IF_D_W'(dat) : '0;
  assign dbi_mem_com_o        = DBI_IF_D_W'(8'h2C);
  assign dbi_ctrl_mode_o      = state_q == DONE ? 2'd2 : state_q == IDLE ? 2'd0 : 2'd1;
  assign busy_o               = issue | (state_q == SLP_WAIT);
  assign init_done_o          = state_q == DONE;
  assign type_hs              = issue & tx.tx_type_rdy_i;
  assign data_hs              = tx.tx_data_vld_o & tx.tx_data_rdy_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      byte_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= ISSUE;
          step_q  <= 3'd0;
          byte_q  <= 2'd0;
        end
        ISSUE: if (type_hs) begin
          byte_q  <= 2'd0;
          cnt_q   <= CW'(SLP_WAIT_CYC - 1);
          state_q <= step_q == 3'd1 ? SLP_WAIT : step_q == 3'd6 ? DONE : ISSUE;
          step_q  <= step_q == 3'd6 ? step_q : step_q + 3'd1;
        end else if (data_hs && {1'b0, byte_q} != amt - 3'd1) begin
          byte_q <= byte_q + 2'd1;
        end
        SLP_WAIT: if (cnt_q == '0) begin
          state_q <= ISSUE;
          step_q  <= 3'd2;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_dbi_init_seq.sv
// tb_dbi_init_seq: table-driven vectors plus hand sequences for stall, backpressure, restart and mid-script reset.
module tb_dbi_init_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] mode;
  logic [7:0] mem_com;
  logic       busy, done;
  int         n_tests = 0;
  int         n_fail = 0;

  dbi_init_seq_if #(.DBI_IF_D_W(8)) tx ();

  dbi_init_seq #(.INTERNAL_CLK(1000), .SLP_WAIT_MS(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .dbi_ctrl_mode_o(mode),
    .dbi_mem_com_o(mem_com),
    .busy_o(busy),
    .init_done_o(done),
    .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, trdy, drdy;
    logic [26:0] exp;
  } vec_t;
  vec_t v[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] outv();
    return {tx.tx_type_vld_o, tx.tx_type_hrst_o, tx.tx_type_dat_amt_o, tx.tx_com_vld_o, tx.tx_com_o,
            tx.tx_data_vld_o, tx.tx_data_o, mode, busy, done};
  endfunction

  function automatic logic [26:0] mk(input logic tvld, input logic hrst, input logic [2:0] amt, input logic cvld,
                                     input logic [7:0] com, input logic dvld, input logic [7:0] dat,
                                     input logic [1:0] md, input logic bsy, input logic dn);
    return {tvld, hrst, amt, cvld, com, dvld, dat, md, bsy, dn};
  endfunction

  initial begin
    int          bad, n, beats, cyc, stable;
    logic [31:0] bytes;
    tx.tx_type_rdy_i = 1'b0;
    tx.tx_com_rdy_i  = 1'b1;
    tx.tx_data_rdy_i = 1'b0;
    v[0]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 2'd0, 0, 0)};
    v[1]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 3'd0, 0, 8'h00, 0, 8'h00, 2'd1, 1, 0)};
    v[2]  = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd0, 1, 8'h11, 0, 8'h00, 2'd1, 1, 0)};
    for (int i = 3; i <= 8; i++)
      v[i] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 2'd1, 1, 0)};
    v[9]  = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd1, 1, 8'h36, 1, 8'h48, 2'd1, 1, 0)};
    v[10] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd1, 1, 8'h3A, 1, 8'h55, 2'd1, 1, 0)};
    v[11] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2A, 1, 8'h00, 2'd1, 1, 0)};
    v[12] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2A, 1, 8'h00, 2'd1, 1, 0)};
    v[13] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2A, 1, 8'h00, 2'd1, 1, 0)};
    v[14] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd4, 1, 8'h2A, 1, 8'hEF, 2'd1, 1, 0)};
    v[15] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2B, 1, 8'h00, 2'd1, 1, 0)};
    v[16] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2B, 1, 8'h00, 2'd1, 1, 0)};
    v[17] = '{1'b0, 1'b0, 1'b1, mk(1, 0, 3'd4, 1, 8'h2B, 1, 8'h01, 2'd1, 1, 0)};
    v[18] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd4, 1, 8'h2B, 1, 8'h3F, 2'd1, 1, 0)};
    v[19] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 3'd0, 1, 8'h29, 0, 8'h00, 2'd1, 1, 0)};
    v[20] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 2'd2, 0, 1)};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("vec%0d", i), 32'(outv()), 32'(v[i].exp));
      start_i          = v[i].start;
      tx.tx_type_rdy_i = v[i].trdy;
      tx.tx_data_rdy_i = v[i].drdy;
      @(negedge clk);
    end
    chk("mem_com", 32'(mem_com), 32'h2C);
    chk("type_rw", 32'(tx.tx_type_rw_o), 32'h0);

    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("restart", 32'({mode, tx.tx_type_vld_o, tx.tx_type_hrst_o}), 32'({2'd1, 1'b1, 1'b1}));

    bad = 0;
    repeat (50) begin
      if (!(tx.tx_type_vld_o && tx.tx_type_hrst_o && busy && tx.tx_com_o == 8'h00 && !tx.tx_com_vld_o)) bad++;
      @(negedge clk);
    end
    chk("stall_step0", 32'(bad), 32'd0);
    tx.tx_type_rdy_i = 1'b1;
    @(negedge clk);
    chk("step1_com", 32'({tx.tx_com_vld_o, tx.tx_com_o}), 32'h111);
    @(negedge clk);
    tx.tx_type_rdy_i = 1'b0;

    n = 0;
    while (!tx.tx_type_vld_o && n < 20) begin
      start_i = (n == 1);
      n++;
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("slp_cycles", 32'(n), 32'd6);
    chk("step2_after_wait", 32'({tx.tx_com_o, tx.tx_data_o}), 32'h3648);

    tx.tx_type_rdy_i = 1'b1;
    tx.tx_data_rdy_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx.tx_type_rdy_i = 1'b0;
    tx.tx_data_rdy_i = 1'b0;

    beats = 0;
    cyc = 0;
    stable = 1;
    bytes = '0;
    while (beats < 4 && cyc < 40) begin
      if (tx.tx_com_o != 8'h2A || !tx.tx_type_vld_o) stable = 0;
      tx.tx_data_rdy_i = (cyc % 3 == 2);
      tx.tx_type_rdy_i = tx.tx_data_rdy_i && beats == 3;
      if (tx.tx_data_rdy_i && tx.tx_data_vld_o) begin
        bytes = {bytes[23:0], tx.tx_data_o};
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    tx.tx_type_rdy_i = 1'b0;
    tx.tx_data_rdy_i = 1'b0;
    chk("bp_beats", 32'(beats), 32'd4);
    chk("bp_bytes", bytes, 32'h000000EF);
    chk("bp_com_stable", 32'(stable), 32'd1);
    chk("bp_next_step", 32'({tx.tx_com_o, tx.tx_data_o}), 32'h2B00);

    tx.tx_data_rdy_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx.tx_data_rdy_i = 1'b0;
    chk("raset_b2", 32'(tx.tx_data_o), 32'h01);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({tx.tx_type_vld_o, tx.tx_com_vld_o, tx.tx_data_vld_o, mode, busy, done}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef DBI_INIT_AUTO_START_EN
    chk("post_rst", 32'({mode, tx.tx_type_vld_o, tx.tx_type_hrst_o}), 32'({2'd1, 1'b1, 1'b1}));
`else
    chk("post_rst", 32'({mode, tx.tx_type_vld_o, tx.tx_type_hrst_o}), 32'({2'd0, 1'b0, 1'b0}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
